mult_div_unit: RTL and testbench

// - Multi-cycle multiply/divide unit with its HI/LO registers for the P6 five-stage MIPS core; sits in the E stage.
// - Sequences mult/multu/div/divu over a fixed latency, serves mthi/mtlo writes and mfhi/mflo reads.
// - Produces the D-stage stall request while the unit is occupied.
// - Driven by the decoder outputs start, mudiOp, hiWrite, loWrite, hiRead and loRead.

---
 rtl/mult_div_unit.sv | 138 +++++++++++++
 tb/tb_mult_div_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with the architectural HI/LO registers.
// It sits in the E stage. An operation computes its 64-bit result on the
// start edge and then holds it as pending. The result commits to HI/LO on
// the last busy edge, and the unit raises a D-stage stall while occupied.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mudiOp,
    input  logic        hiWrite,
    input  logic        loWrite,
    input  logic        hiRead,
    input  logic        loRead,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        mdUseD,
    output logic        busy,
    output logic        mdStall,
    output logic [31:0] hiLoOut,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_commit;

    logic               op_valid;
    logic               is_div;
    logic               div_zero;
    logic [31:0]        divisor;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic [63:0]        result;

    // Arithmetic datapath: the result of the operation on the current operands
    always_comb begin
        op_valid = (mudiOp[2] == 1'b0);
        is_div   = mudiOp[1];
        div_zero = (srcB == '0);
        // Substitute a divisor of 1 when it is zero. This keeps the divider
        // defined. The result is discarded through pend_commit anyway.
        divisor  = div_zero ? 32'd1 : srcB;

        prod_s = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
        prod_u = {32'b0, srcA} * {32'b0, srcB};

        // The most negative value divided by -1 overflows a 32-bit quotient.
        // Its architectural result is spelled out explicitly here.
        if (srcA == 32'h8000_0000 && srcB == 32'hFFFF_FFFF) begin
            quot_s = 32'h8000_0000;
            rem_s  = '0;
        end else begin
            quot_s = $signed(srcA) / $signed(divisor);
            rem_s  = $signed(srcA) % $signed(divisor);
        end
        quot_u = srcA / divisor;
        rem_u  = srcA % divisor;

        case (mudiOp[1:0])
            2'b00:   result = prod_s;
            2'b01:   result = prod_u;
            2'b10:   result = {rem_s, quot_s};
            default: result = {rem_u, quot_u};
        endcase
    end

    // Control FSM, busy counter and HI/LO state, all updated together
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            busy        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            pend_hi     <= '0;
            pend_lo     <= '0;
            pend_commit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && op_valid) begin
                        pend_hi     <= result[63:32];
                        pend_lo     <= result[31:0];
                        pend_commit <= !(is_div && div_zero);
                        count       <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state       <= BUSY;
                        busy        <= 1'b1;
                    end else begin
                        if (hiWrite) hi <= srcA;
                        if (loWrite) lo <= srcA;
                    end
                end
                BUSY: begin
                    if (count == CNT_W'(1)) begin
                        if (pend_commit) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        count <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stall a dependent D-stage instruction from the start cycle until the unit frees up
    assign mdStall = mdUseD & (start | busy);

    // Read mux for mfhi/mflo, committed values only
    assign hiLoOut = hiRead ? hi : (loRead ? lo : 32'h0);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit. Inputs change on the
// falling edge, and outputs are checked on the falling edge.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mudiOp;
    logic        hiWrite;
    logic        loWrite;
    logic        hiRead;
    logic        loRead;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        mdUseD;
    logic        busy;
    logic        mdStall;
    logic [31:0] hiLoOut;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    mult_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mudiOp(mudiOp),
        .hiWrite(hiWrite),
        .loWrite(loWrite),
        .hiRead(hiRead),
        .loRead(loRead),
        .srcA(srcA),
        .srcB(srcB),
        .mdUseD(mdUseD),
        .busy(busy),
        .mdStall(mdStall),
        .hiLoOut(hiLoOut),
        .hi(hi),
        .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and count the busy cycles and the stall cycles,
    // starting from the start cycle. It returns at the first falling edge with busy low.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, output int busy_n, output int stall_n);
        busy_n  = 0;
        stall_n = 0;
        @(negedge clk);
        start  = 1'b1;
        mudiOp = op;
        srcA   = a;
        srcB   = b;
        mdUseD = use_d;
        #1;
        if (mdStall) stall_n++;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            busy_n++;
            if (mdStall) stall_n++;
            @(negedge clk);
        end
        mdUseD = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        hiRead = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++; if (mdStall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", mdStall); end
        checks++; if (hiLoOut !== 32'h0) begin errors++; $display("FAIL reset_hiloout got %h want 0", hiLoOut); end
        hiRead = 1'b0;
    endtask

    task automatic test_mult();
        int bn, sn;
        do_op(3'b000, 32'hFFFF_FFFE, 32'd3, 1'b0, bn, sn);
        checks++; if (bn != 5) begin errors++; $display("FAIL mult_busy got %0d want 5", bn); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", lo); end
        do_op(3'b001, 32'hFFFF_FFFE, 32'd3, 1'b0, bn, sn);
        checks++; if (bn != 5) begin errors++; $display("FAIL multu_busy got %0d want 5", bn); end
        checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi got %h want 00000002", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo got %h want fffffffa", lo); end
    endtask

    task automatic test_div();
        int bn, sn;
        do_op(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0, bn, sn);
        checks++; if (bn != 10) begin errors++; $display("FAIL div_busy got %0d want 10", bn); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
        do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bn, sn);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want 0", hi); end
        do_op(3'b011, 32'd100, 32'd7, 1'b0, bn, sn);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h want 00000002", hi); end
        do_op(3'b011, 32'd7, 32'd0, 1'b0, bn, sn);
        checks++; if (bn != 10) begin errors++; $display("FAIL divzero_busy got %0d want 10", bn); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divzero_lo got %h want 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divzero_hi got %h want 00000002", hi); end
    endtask

    task automatic test_stall();
        int bn, sn;
        do_op(3'b001, 32'd1, 32'd1, 1'b1, bn, sn);
        checks++; if (sn != 6) begin errors++; $display("FAIL stall_dep got %0d want 6", sn); end
        #1;
        checks++; if (mdStall !== 1'b0) begin errors++; $display("FAIL stall_after got %0b want 0", mdStall); end
        do_op(3'b001, 32'd0, 32'd0, 1'b0, bn, sn);
        checks++; if (sn != 0) begin errors++; $display("FAIL stall_indep got %0d want 0", sn); end
        checks++; if (bn != 5) begin errors++; $display("FAIL stall_indep_busy got %0d want 5", bn); end
    endtask

    task automatic test_hilo_write();
        @(negedge clk);
        hiWrite = 1'b1;
        srcA    = 32'h0000_1234;
        @(negedge clk);
        hiWrite = 1'b0;
        checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi got %h want 00001234", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %0b want 0", busy); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mthi_lo got %h want 0", lo); end
        hiWrite = 1'b1;
        loWrite = 1'b1;
        srcA    = 32'h0000_ABCD;
        @(negedge clk);
        hiWrite = 1'b0;
        loWrite = 1'b0;
        checks++; if (hi !== 32'h0000_ABCD) begin errors++; $display("FAIL both_hi got %h want 0000abcd", hi); end
        checks++; if (lo !== 32'h0000_ABCD) begin errors++; $display("FAIL both_lo got %h want 0000abcd", lo); end
    endtask

    task automatic test_busy_ignore();
        int n;
        @(negedge clk);
        start  = 1'b1;
        mudiOp = 3'b000;
        srcA   = 32'd2;
        srcB   = 32'd3;
        @(negedge clk);
        start   = 1'b0;
        hiWrite = 1'b1;
        loWrite = 1'b1;
        srcA    = 32'hDEAD_BEEF;
        @(negedge clk);
        hiWrite = 1'b0;
        loWrite = 1'b0;
        hiRead  = 1'b1;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %0b want 1", busy); end
        checks++; if (hi !== 32'h0000_ABCD) begin errors++; $display("FAIL ign_hi got %h want 0000abcd", hi); end
        checks++; if (hiLoOut !== 32'h0000_ABCD) begin errors++; $display("FAIL nobypass got %h want 0000abcd", hiLoOut); end
        hiRead = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ign_res_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL ign_res_lo got %h want 00000006", lo); end
    endtask

    task automatic test_start_with_write();
        int n;
        @(negedge clk);
        start   = 1'b1;
        loWrite = 1'b1;
        mudiOp  = 3'b000;
        srcA    = 32'd4;
        srcB    = 32'd5;
        @(negedge clk);
        start   = 1'b0;
        loWrite = 1'b0;
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL sw_dropped got %h want 00000006", lo); end
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL sw_busy got %0d want 5", n); end
        checks++; if (lo !== 32'd20) begin errors++; $display("FAIL sw_lo got %h want 00000014", lo); end
    endtask

    task automatic test_invalid_op();
        @(negedge clk);
        start  = 1'b1;
        mudiOp = 3'b100;
        srcA   = 32'd9;
        srcB   = 32'd9;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inv_busy got %0b want 0", busy); end
        checks++; if (lo !== 32'd20) begin errors++; $display("FAIL inv_lo got %h want 00000014", lo); end
    endtask

    task automatic test_read_mux();
        @(negedge clk);
        hiWrite = 1'b1;
        srcA    = 32'h1111_1111;
        @(negedge clk);
        hiWrite = 1'b0;
        loWrite = 1'b1;
        srcA    = 32'h2222_2222;
        @(negedge clk);
        loWrite = 1'b0;
        hiRead = 1'b1; loRead = 1'b0; #1;
        checks++; if (hiLoOut !== 32'h1111_1111) begin errors++; $display("FAIL mfhi got %h want 11111111", hiLoOut); end
        hiRead = 1'b0; loRead = 1'b1; #1;
        checks++; if (hiLoOut !== 32'h2222_2222) begin errors++; $display("FAIL mflo got %h want 22222222", hiLoOut); end
        hiRead = 1'b1; loRead = 1'b1; #1;
        checks++; if (hiLoOut !== 32'h1111_1111) begin errors++; $display("FAIL rd_prio got %h want 11111111", hiLoOut); end
        hiRead = 1'b0; loRead = 1'b0; #1;
        checks++; if (hiLoOut !== 32'h0) begin errors++; $display("FAIL rd_none got %h want 0", hiLoOut); end
    endtask

    task automatic test_reset_mid();
        int bn, sn;
        @(negedge clk);
        start  = 1'b1;
        mudiOp = 3'b011;
        srcA   = 32'd100;
        srcB   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo got %h want 0", lo); end
        do_op(3'b000, 32'd3, 32'd7, 1'b0, bn, sn);
        checks++; if (bn != 5) begin errors++; $display("FAIL post_busy got %0d want 5", bn); end
        checks++; if (lo !== 32'd21) begin errors++; $display("FAIL post_lo got %h want 00000015", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL post_hi got %h want 0", hi); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        mudiOp  = 3'b000;
        hiWrite = 1'b0;
        loWrite = 1'b0;
        hiRead  = 1'b0;
        loRead  = 1'b0;
        srcA    = '0;
        srcB    = '0;
        mdUseD  = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_hilo_write();
        test_busy_ignore();
        test_start_with_write();
        test_invalid_op();
        test_read_mux();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
